// File: rtl/prl_rx_message_if.sv
// prl_rx_message_if: buffers received PRL messages in a FIFO and hands them to the PE one at a time.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   prl_rx_st_message_if_*           one-cycle message pulse from the PRL RX state machine plus its fields
//   prl_rx_if_clear                  flush pulse on protocol hard/soft reset
//   prl_rx_if_full / prl_rx_if_drop  registered FIFO-full level / one-cycle overflow drop pulse
//   pl2pe_rx_en, pl2pe_rx_*          level-valid presentation of the head entry (data zero when not valid)
//   pe2pl_rx_ack                     one-cycle consume pulse from the PE
//   pl2pe_rx_timeout                 one-cycle pulse when the PE leaves a message unacknowledged too long
module prl_rx_message_if #(
  parameter int          DEPTH       = 2,
  parameter int          PTR_W       = 1,
  parameter logic [15:0] ACK_TIMEOUT = 16'd1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        prl_rx_st_message_if_en,
  input  logic [2:0]  prl_rx_st_message_if_sop_type,
  input  logic [1:0]  prl_rx_st_message_if_message_type,
  input  logic [4:0]  prl_rx_st_message_if_header_type,
  input  logic [4:0]  prl_rx_st_message_if_info,
  input  logic [35:0] prl_rx_st_message_if_ex_info,
  input  logic        prl_rx_if_clear,
  output logic        prl_rx_if_full,
  output logic        prl_rx_if_drop,
  output logic        pl2pe_rx_en,
  output logic [6:0]  pl2pe_rx_type,
  output logic [2:0]  pl2pe_rx_sop_type,
  output logic [4:0]  pl2pe_rx_info,
  output logic [35:0] pl2pe_rx_ex_info,
  input  logic        pe2pl_rx_ack,
  output logic        pl2pe_rx_timeout
);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, VALID, GAP} state_t;
  state_t           state, state_n;
  logic [50:0]      mem [DEPTH];
  logic [50:0]      head, wr_data;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count, count_n;
  logic [15:0]      timer, timer_n;
  logic             push, pop, timeout_n;
  assign wr_data = {prl_rx_st_message_if_sop_type, prl_rx_st_message_if_message_type,
                    prl_rx_st_message_if_header_type, prl_rx_st_message_if_info,
                    prl_rx_st_message_if_ex_info};
  assign head              = mem[rd_ptr];
  assign pl2pe_rx_en       = (state == VALID);
  assign pl2pe_rx_sop_type = pl2pe_rx_en ? head[50:48] : '0;
  assign pl2pe_rx_type     = pl2pe_rx_en ? head[47:41] : '0;
  assign pl2pe_rx_info     = pl2pe_rx_en ? head[40:36] : '0;
  assign pl2pe_rx_ex_info  = pl2pe_rx_en ? head[35:0]  : '0;
  // Clear swallows any same-cycle push or ack; a full FIFO still accepts when the head pops.
  always_comb begin
    pop       = pe2pl_rx_ack && pl2pe_rx_en && !prl_rx_if_clear;
    push      = prl_rx_st_message_if_en && !prl_rx_if_clear && (count != FULL_CNT || pop);
    count_n   = count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    timer_n   = (prl_rx_if_clear || pop || !pl2pe_rx_en) ? '0 :
                (timer != ACK_TIMEOUT) ? timer + 16'd1 : timer;
    // Timer saturates one past the trigger value, so the pulse fires once per entry.
    timeout_n = pl2pe_rx_en && !pop && !prl_rx_if_clear && (timer == ACK_TIMEOUT - 16'd1);
    state_n   = state;
    case (state)
      IDLE:    state_n = (count != '0 || push) ? VALID : IDLE;
      VALID:   state_n = pop ? GAP : VALID;
      GAP:     state_n = (count_n != '0) ? VALID : IDLE;
      default: state_n = IDLE;
    endcase
    if (prl_rx_if_clear) state_n = IDLE;
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      timer            <= '0;
      prl_rx_if_full   <= 1'b0;
      prl_rx_if_drop   <= 1'b0;
      pl2pe_rx_timeout <= 1'b0;
    end else begin
      state            <= state_n;
      wr_ptr           <= prl_rx_if_clear ? '0 : wr_ptr + PTR_W'(push);
      rd_ptr           <= prl_rx_if_clear ? '0 : rd_ptr + PTR_W'(pop);
      count            <= prl_rx_if_clear ? '0 : count_n;
      timer            <= timer_n;
      prl_rx_if_full   <= !prl_rx_if_clear && (count_n == FULL_CNT);
      prl_rx_if_drop   <= prl_rx_st_message_if_en && !push && !prl_rx_if_clear;
      pl2pe_rx_timeout <= timeout_n;
    end
  end
endmodule

// File: tb/tb_prl_rx_message_if.sv
// tb_prl_rx_message_if: directed and randomized checks of prl_rx_message_if against a queue-based model.
module tb_prl_rx_message_if;
  localparam int DEPTH = 2;
  localparam int TO    = 8;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [2:0]  sop = '0;
  logic [1:0]  mt = '0;
  logic [4:0]  ht = '0;
  logic [4:0]  info = '0;
  logic [35:0] ex = '0;
  logic        clr = 1'b0;
  logic        ack = 1'b0;
  logic        full, drop, rx_en, tmo;
  logic [6:0]  rx_type;
  logic [2:0]  rx_sop;
  logic [4:0]  rx_info;
  logic [35:0] rx_ex;
  int          tests = 0;
  int          fails = 0;
  logic [50:0] q[$];
  bit          m_en, m_fired, exp_drop, exp_to;
  int          m_age;
  always #5 clk = ~clk;
  prl_rx_message_if #(.DEPTH(DEPTH), .PTR_W(1), .ACK_TIMEOUT(16'(TO))) dut (
    .clk(clk), .rst_n(rst_n),
    .prl_rx_st_message_if_en(en), .prl_rx_st_message_if_sop_type(sop),
    .prl_rx_st_message_if_message_type(mt), .prl_rx_st_message_if_header_type(ht),
    .prl_rx_st_message_if_info(info), .prl_rx_st_message_if_ex_info(ex),
    .prl_rx_if_clear(clr), .prl_rx_if_full(full), .prl_rx_if_drop(drop),
    .pl2pe_rx_en(rx_en), .pl2pe_rx_type(rx_type), .pl2pe_rx_sop_type(rx_sop),
    .pl2pe_rx_info(rx_info), .pl2pe_rx_ex_info(rx_ex),
    .pe2pl_rx_ack(ack), .pl2pe_rx_timeout(tmo)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    q.delete();
    m_en = 0; m_fired = 0; m_age = 0; exp_drop = 0; exp_to = 0;
  endtask
  // Transaction-level view: queue of pending messages, head shown when m_en, one dead cycle after each consume.
  task automatic model_step(input bit e, input logic [50:0] d, input bit a, input bit c);
    bit popped;
    if (c) begin
      model_reset();
      return;
    end
    popped   = a && m_en;
    exp_to   = m_en && !popped && !m_fired && (m_age == TO - 1);
    if (exp_to) m_fired = 1;
    if (popped) void'(q.pop_front());
    exp_drop = 0;
    if (e) begin
      if (q.size() < DEPTH) q.push_back(d);
      else exp_drop = 1;
    end
    if (popped) m_en = 0;
    else if (m_en) m_age++;
    else if (q.size() > 0) begin
      m_en = 1; m_age = 0; m_fired = 0;
    end
  endtask
  task automatic check_all();
    logic [50:0] h;
    h = (m_en && q.size() > 0) ? q[0] : '0;
    chk("en",      rx_en,   m_en);
    chk("type",    rx_type, h[47:41]);
    chk("sop",     rx_sop,  h[50:48]);
    chk("info",    rx_info, h[40:36]);
    chk("ex_info", rx_ex,   h[35:0]);
    chk("full",    full,    q.size() == DEPTH);
    chk("drop",    drop,    exp_drop);
    chk("timeout", tmo,     exp_to);
  endtask
  task automatic step(input bit e, input logic [2:0] s, input logic [6:0] ty, input logic [4:0] inf,
                      input logic [35:0] x, input bit a, input bit c);
    en = e; sop = s; mt = ty[6:5]; ht = ty[4:0]; info = inf; ex = x; ack = a; clr = c;
    @(posedge clk);
    model_step(e, {s, ty, inf, x}, a, c);
    @(negedge clk);
    en = 0; ack = 0; clr = 0;
    check_all();
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic drain();
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0, 1, 0);
  endtask
  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check_all();
    rst_n = 1'b1;
    idle(2);
    // single message
    step(1, 3'd0, 7'b01_00001, 5'h13, 36'h0, 0, 0);
    chk("single_en", rx_en, 1'b1);
    chk("single_type", rx_type, 7'h21);
    chk("single_info", rx_info, 5'h13);
    idle(2);
    step(0, 0, 0, 0, 0, 1, 0);
    chk("single_release", rx_en, 1'b0);
    idle(2);
    // back-to-back
    step(1, 3'd1, 7'h22, 5'h01, 36'h1_2345_6789, 0, 0);
    step(1, 3'd2, 7'h45, 5'h02, 36'hA_BCDE_F012, 0, 0);
    chk("b2b_full", full, 1'b1);
    idle(1);
    step(0, 0, 0, 0, 0, 1, 0);
    chk("b2b_gap", rx_en, 1'b0);
    chk("b2b_full_clear", full, 1'b0);
    idle(1);
    chk("b2b_second_en", rx_en, 1'b1);
    chk("b2b_second_type", rx_type, 7'h45);
    drain();
    // overflow
    step(1, 3'd3, 7'h01, 5'h03, 36'h3, 0, 0);
    step(1, 3'd4, 7'h02, 5'h04, 36'h4, 0, 0);
    step(1, 3'd5, 7'h03, 5'h05, 36'h5, 0, 0);
    chk("ovf_drop", drop, 1'b1);
    idle(1);
    chk("ovf_drop_pulse", drop, 1'b0);
    drain();
    // full with simultaneous ack and push
    step(1, 3'd1, 7'h11, 5'h06, 36'h6, 0, 0);
    step(1, 3'd2, 7'h12, 5'h07, 36'h7, 0, 0);
    step(1, 3'd3, 7'h13, 5'h08, 36'h8, 1, 0);
    chk("fullpp_drop", drop, 1'b0);
    chk("fullpp_full", full, 1'b1);
    drain();
    // timeout
    step(1, 3'd6, 7'h2A, 5'h09, 36'h9, 0, 0);
    idle(12);
    step(0, 0, 0, 0, 0, 1, 0);
    chk("to_pop", rx_en, 1'b0);
    idle(2);
    // clear with pending entries and concurrent push
    step(1, 3'd1, 7'h31, 5'h0A, 36'hA, 0, 0);
    step(1, 3'd2, 7'h32, 5'h0B, 36'hB, 0, 0);
    step(1, 3'd3, 7'h33, 5'h0C, 36'hC, 1, 1);
    chk("clr_en", rx_en, 1'b0);
    chk("clr_full", full, 1'b0);
    chk("clr_drop", drop, 1'b0);
    step(0, 0, 0, 0, 0, 1, 0);
    idle(2);
    // asynchronous reset mid-handshake
    step(1, 3'd5, 7'h3F, 5'h1F, 36'hF_FFFF_FFFF, 0, 0);
    step(1, 3'd4, 7'h3E, 5'h1E, 36'hE, 0, 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      automatic int ack_div = (i / 200 == 1) ? 20 : 3;
      step($urandom_range(0, 2) == 0, 3'($urandom), 7'($urandom), 5'($urandom),
           {4'($urandom), 32'($urandom)}, $urandom_range(0, ack_div - 1) == 0,
           $urandom_range(0, 49) == 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
